// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: one iterative shift-add multiplier shared by two requesters under round-robin arbitration.
// Define MUL_RR_SIGNED_EN for two's-complement operands and product; the default build is unsigned.
module mul_rr_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               out_id
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef MUL_RR_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic              gnt0_q;
    logic              gnt1_q;
    logic              busy_q;
    logic              out_valid_q;
    logic              out_id_q;
    logic              last_id_q;
    logic              job_id_q;
    logic [PW-1:0]     out_q;
    logic [CW-1:0]     cnt_q;

    logic [PW-1:0]     mcand_q;
    logic [PW-1:0]     mcand_d;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     acc_d;
    logic [WIDTH-1:0]  mplier_q;
    logic [WIDTH-1:0]  mplier_d;

    logic              any_req;
    logic              win_id;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              last_iter;

    // The multiplicand is kept pre-shifted, so each iteration adds it in place.
    function automatic logic [PW-1:0] extend(input logic [WIDTH-1:0] v);
        return {{WIDTH{SIGNED_EN & v[WIDTH-1]}}, v};
    endfunction

    always_comb begin
        any_req   = req0 | req1;
        win_id    = (req0 & req1) ? ~last_id_q : req1;
        sel_a     = win_id ? a1 : a0;
        sel_b     = win_id ? b1 : b0;
        last_iter = (cnt_q == CNT_LAST);
        acc_d     = acc_q;
        if (mplier_q[0]) begin
            // In two's complement the MSB carries negative weight.
            if (SIGNED_EN && last_iter) begin
                acc_d = acc_q - mcand_q;
            end else begin
                acc_d = acc_q + mcand_q;
            end
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && any_req) begin
            mcand_q  <= extend(sel_a);
            mplier_q <= sel_b;
            acc_q    <= '0;
        end else if (state_q == S_RUN) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            last_id_q   <= 1'b1;
            job_id_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt0_q    <= ~win_id;
                        gnt1_q    <= win_id;
                        last_id_q <= win_id;
                        job_id_q  <= win_id;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last_iter) begin
                        out_q       <= acc_d;
                        out_id_q    <= job_id_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = busy_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: vector table, hand-written corner sequences and random traffic
// checked every cycle against a timeline model of grants, busy windows and completions.
module tb_mul_rr_scheduler;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic          CLK = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          gnt0, gnt1, busy, out_valid, out_id;
    logic [PW-1:0] out;

    int checks = 0;
    int errors = 0;

    // Model: a job granted at edge S completes at edge S+W; the next grant is no earlier than S+W+2.
    int            cyc       = 0;
    int            job_start = -1000;
    int            next_ok   = 0;
    bit            m_last    = 1'b1;
    bit            m_id      = 1'b0;
    bit            job_id    = 1'b0;
    logic [PW-1:0] m_out     = '0;
    logic [PW-1:0] job_prod  = '0;
    bit            e_gnt0, e_gnt1, e_busy, e_vld;

    typedef struct {
        bit           r0;
        bit           r1;
        logic [W-1:0] va0, vb0, va1, vb1;
        bit           eid;
        logic [PW-1:0] eu;
        logic [PW-1:0] es;
    } vec_t;

    vec_t tbl[10];

    mul_rr_scheduler #(.WIDTH(W)) dut (
        .CLK(CLK), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .out(out), .out_valid(out_valid), .out_id(out_id)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input bit r0, input bit r1, input int x0, input int y0,
                                input int x1, input int y1, input bit id, input int eu, input int es);
        vec_t v;
        v.r0 = r0; v.r1 = r1;
        v.va0 = W'(x0); v.vb0 = W'(y0); v.va1 = W'(x1); v.vb1 = W'(y1);
        v.eid = id; v.eu = PW'(eu); v.es = PW'(es);
        return v;
    endfunction

    function automatic logic [PW-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_RR_SIGNED_EN
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return PW'(sx * sy);
`else
        int ux, uy;
        ux = int'(x);
        uy = int'(y);
        return PW'(ux * uy);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit win;
        e_gnt0 = 1'b0;
        e_gnt1 = 1'b0;
        e_vld  = 1'b0;
        if (cyc >= next_ok && (req0 || req1)) begin
            win       = (req0 && req1) ? ~m_last : req1;
            job_start = cyc;
            next_ok   = cyc + W + 2;
            job_id    = win;
            m_last    = win;
            job_prod  = win ? model_mul(a1, b1) : model_mul(a0, b0);
            e_gnt0    = ~win;
            e_gnt1    = win;
        end
        if (cyc == job_start + W) begin
            e_vld = 1'b1;
            m_out = job_prod;
            m_id  = job_id;
        end
        e_busy = (cyc >= job_start) && (cyc <= job_start + W);
    endtask

    task automatic step(input bit drop);
        model_edge();
        @(posedge CLK);
        #1;
        check("gnt0", gnt0, e_gnt0);
        check("gnt1", gnt1, e_gnt1);
        check("busy", busy, e_busy);
        check("out_valid", out_valid, e_vld);
        check("out", out, m_out);
        check("out_id", out_id, m_id);
        if (drop && gnt0) req0 = 1'b0;
        if (drop && gnt1) req1 = 1'b0;
        cyc++;
    endtask

    task automatic model_reset();
        job_start = -1000;
        next_ok   = 0;
        m_last    = 1'b1;
        m_out     = '0;
        m_id      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, gnt0, 0);
        check({tag, "_gnt1"}, gnt1, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out"}, out, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_id"}, out_id, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge CLK);
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(1) << (W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [PW-1:0] exp_out;
        bit            got;
        int            g0_cyc, g1_cyc;
        logic [PW-1:0] q_out[$];
        bit            q_id[$];

        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        tbl[0] = mk(1, 0,   3,   9,   0,   0, 0,    27,    27);
        tbl[1] = mk(1, 1,  10,  14, 123,   7, 0,   140,   140);
        tbl[2] = mk(0, 1,   0,   0, 255, 255, 1, 65025,     1);
        tbl[3] = mk(1, 0,   0, 200,   0,   0, 0,     0,     0);
        tbl[4] = mk(0, 1,   0,   0, 200,   0, 1,     0,     0);
        tbl[5] = mk(1, 0, 255,   1,   0,   0, 0,   255, 16'hFFFF);
        tbl[6] = mk(0, 1,   0,   0, 128, 128, 1, 16384, 16384);
        tbl[7] = mk(1, 0, 253,   9,   0,   0, 0,  2277, 16'hFFE5);
        tbl[8] = mk(0, 1,   0,   0, 128, 255, 1, 32640,   128);
        tbl[9] = mk(1, 0, 127, 128,   0,   0, 0, 16256, 16'hC080);

        // Single jobs from reset: first result and its id.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            req0 = tbl[i].r0; a0 = tbl[i].va0; b0 = tbl[i].vb0;
            req1 = tbl[i].r1; a1 = tbl[i].va1; b1 = tbl[i].vb1;
`ifdef MUL_RR_SIGNED_EN
            exp_out = tbl[i].es;
`else
            exp_out = tbl[i].eu;
`endif
            got = 1'b0;
            for (int k = 0; k < 3 * W && !got; k++) begin
                step(1'b1);
                if (out_valid) begin
                    got = 1'b1;
                    check("vec_out", out, exp_out);
                    check("vec_id", out_id, tbl[i].eid);
                end
            end
            check("vec_done", got, 1);
            req0 = 1'b0; req1 = 1'b0;
            step(1'b1); step(1'b1);
        end

        // Simultaneous requests: requester 0 first, grants W+2 cycles apart.
        do_reset();
        req0 = 1'b1; a0 = 8'd10;  b0 = 8'd14;
        req1 = 1'b1; a1 = 8'd123; b1 = 8'd7;
        g0_cyc = -1; g1_cyc = -1;
        q_out.delete(); q_id.delete();
        for (int k = 0; k < 3 * W + 6; k++) begin
            step(1'b1);
            if (gnt0 && g0_cyc < 0) g0_cyc = cyc;
            if (gnt1 && g1_cyc < 0) g1_cyc = cyc;
            if (out_valid) begin q_out.push_back(out); q_id.push_back(out_id); end
        end
        check("t2_gnt_gap", g1_cyc - g0_cyc, W + 2);
        check("t2_count", q_out.size(), 2);
        if (q_out.size() >= 2) begin
            check("t2_out0", q_out[0], 140);
            check("t2_id0", q_id[0], 0);
            check("t2_out1", q_out[1], 861);
            check("t2_id1", q_id[1], 1);
        end

        // Both requesters held high: strict alternation.
        do_reset();
        req0 = 1'b1; a0 = 8'd11; b0 = 8'd60;
        req1 = 1'b1; a1 = 8'd0;  b1 = 8'd3;
        q_out.delete(); q_id.delete();
        for (int k = 0; k < 4 * (W + 2); k++) begin
            step(1'b0);
            if (out_valid) begin q_out.push_back(out); q_id.push_back(out_id); end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < W + 3; k++) step(1'b1);
        check("t3_count", q_out.size(), 4);
        for (int k = 0; k < 4 && k < q_out.size(); k++) begin
            check("t3_id", q_id[k], k % 2);
            check("t3_out", q_out[k], (k % 2) ? 0 : 660);
        end

        // Reset four cycles into a job: silent abort, tie goes to requester 0 afterwards.
        do_reset();
        req0 = 1'b1; a0 = 8'd5; b0 = 8'd7;
        step(1'b1);
        for (int k = 0; k < 4; k++) step(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        @(posedge CLK);
        #1;
        check("t5_hold_valid", out_valid, 0);
        check("t5_hold_busy", busy, 0);
        @(negedge CLK);
        reset = 1'b0;
        model_reset();
        req0 = 1'b1; a0 = 8'd6; b0 = 8'd7;
        req1 = 1'b1; a1 = 8'd2; b1 = 8'd3;
        step(1'b1);
        check("t5_tie_gnt0", gnt0, 1);
        for (int k = 0; k < 2 * (W + 2) + 2; k++) step(1'b1);

        // Random traffic with requesters that hold operands until granted.
        do_reset();
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; a0 = rand_op(); b0 = rand_op();
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; a1 = rand_op(); b1 = rand_op();
            end
            step(1'b1);
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < W + 3; k++) step(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
